// File: rtl/s_axi_mem_pkg.sv
// Shared AXI constants, FSM state types and burst-attribute helpers for the
// s_axi_mem slave.
package s_axi_mem_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } burst_attr_t;

  // Only full-width INCR bursts are serviced.
  function automatic logic burst_ok(input burst_attr_t attr, input logic [SIZE_W-1:0] full_size);
    return (attr.burst == BURST_INCR) && (attr.size == full_size);
  endfunction

endpackage

// File: rtl/s_axi_mem_if.sv
// AXI4 slave bus bundle (AW/W/B/AR/R) without lock/cache/prot/qos/region.
interface s_axi_mem_if
  import s_axi_mem_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_W-1:0]        awlen;
  logic [SIZE_W-1:0]       awsize;
  logic [BURST_W-1:0]      awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [RESP_W-1:0]       bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [LEN_W-1:0]        arlen;
  logic [SIZE_W-1:0]       arsize;
  logic [BURST_W-1:0]      arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_W-1:0]       rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/s_axi_mem_ram.sv
// Word-organised storage: one byte-enabled synchronous write port and one
// asynchronous read port (a same-edge write is not visible to that read).
module axi_mem_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_WIDTH/8-1:0]      wr_strb,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/s_axi_mem.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) FSMs over a
// byte-enabled word RAM; illegal or out-of-range beats answer SLVERR.
module s_axi_mem
  import s_axi_mem_pkg::*;
#(
  parameter logic [63:0] S_TARGET_SLAVE_BASE_ADDR = 64'h4000_0000,
  parameter int unsigned S_AXI_ID_WIDTH           = 1,
  parameter int unsigned S_AXI_ADDR_WIDTH         = 32,
  parameter int unsigned S_AXI_DATA_WIDTH         = 32,
  parameter int unsigned MEM_DEPTH                = 64
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  s_axi_mem_if.slave  s_axi
);
  localparam int unsigned AW    = S_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = S_AXI_DATA_WIDTH;
  localparam int unsigned IW    = S_AXI_ID_WIDTH;
  localparam int unsigned SHIFT = $clog2(DW / 8);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0]     BASE      = AW'(S_TARGET_SLAVE_BASE_ADDR);
  localparam logic [AW-1:0]     DEPTH_A   = AW'(MEM_DEPTH);
  localparam logic [SIZE_W-1:0] FULL_SIZE = SIZE_W'(SHIFT);

  wr_state_t         w_state;
  logic              aw_ready, w_ready, b_valid;
  logic [RESP_W-1:0] b_resp;
  logic [IW-1:0]     w_id;
  logic [LEN_W-1:0]  w_len, w_cnt;
  logic [AW-1:0]     w_idx;
  logic              w_below, w_err, w_past;

  rd_state_t         r_state;
  logic              ar_ready, r_valid, r_last;
  logic [RESP_W-1:0] r_resp;
  logic [DW-1:0]     r_data;
  logic [IW-1:0]     r_id;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [AW-1:0]     r_idx;
  logic              r_below, r_attr_err;

  logic [AW-1:0]     aw_idx_c, ar_idx_c, rd_idx_c;
  logic              w_hs_c, w_range_ok_c, wr_en_c, rd_ok_c, rd_below_c, rd_attr_err_c;
  logic [DW-1:0]     ram_q;

  // Beat index and legality for the write beat in flight and the read beat to load.
  always_comb begin
    aw_idx_c      = (s_axi.awaddr - BASE) >> SHIFT;
    ar_idx_c      = (s_axi.araddr - BASE) >> SHIFT;
    w_hs_c        = (w_state == W_DATA) && w_ready && s_axi.wvalid;
    w_range_ok_c  = !w_below && (w_idx < DEPTH_A);
    wr_en_c       = w_hs_c && !s_axi_areset && w_range_ok_c && !w_err && !w_past;
    rd_idx_c      = (r_state == R_IDLE) ? ar_idx_c : (r_idx + AW'(1));
    rd_below_c    = (r_state == R_IDLE) ? (s_axi.araddr < BASE) : r_below;
    rd_attr_err_c = (r_state == R_IDLE)
                  ? !burst_ok('{len: s_axi.arlen, size: s_axi.arsize, burst: s_axi.arburst}, FULL_SIZE)
                  : r_attr_err;
    rd_ok_c       = !rd_below_c && !rd_attr_err_c && (rd_idx_c < DEPTH_A);
  end

  axi_mem_ram #(.DATA_WIDTH(DW), .DEPTH(MEM_DEPTH)) u_ram (
    .clk     (s_axi_aclk),
    .wr_en   (wr_en_c),
    .wr_addr (IDX_W'(w_idx)),
    .wr_strb (s_axi.wstrb),
    .wr_data (s_axi.wdata),
    .rd_addr (IDX_W'(rd_idx_c)),
    .rd_data (ram_q)
  );

  // Write FSM; errors are sticky for the burst and reported once on B.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      w_id     <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_idx    <= '0;
      w_below  <= 1'b0;
      w_err    <= 1'b0;
      w_past   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_ready <= 1'b1;
          if (aw_ready && s_axi.awvalid) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            w_id     <= s_axi.awid;
            w_len    <= s_axi.awlen;
            w_cnt    <= '0;
            w_idx    <= aw_idx_c;
            w_below  <= (s_axi.awaddr < BASE);
            w_err    <= !burst_ok('{len: s_axi.awlen, size: s_axi.awsize, burst: s_axi.awburst}, FULL_SIZE);
            w_past   <= 1'b0;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs_c) begin
            w_idx <= w_idx + AW'(1);
            w_cnt <= w_cnt + LEN_W'(1);
            if (!w_range_ok_c) w_err <= 1'b1;
            if (s_axi.wlast) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_resp  <= (w_err || !w_range_ok_c || w_past || (w_cnt != w_len)) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else if (w_cnt == w_len) begin
              w_past <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM; the next beat is loaded on the handshake of the current one.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state    <= R_IDLE;
      ar_ready   <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_resp     <= RESP_OKAY;
      r_data     <= '0;
      r_id       <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_below    <= 1'b0;
      r_attr_err <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          ar_ready <= 1'b1;
          if (ar_ready && s_axi.arvalid) begin
            ar_ready   <= 1'b0;
            r_valid    <= 1'b1;
            r_id       <= s_axi.arid;
            r_len      <= s_axi.arlen;
            r_cnt      <= '0;
            r_idx      <= rd_idx_c;
            r_below    <= rd_below_c;
            r_attr_err <= rd_attr_err_c;
            r_data     <= rd_ok_c ? ram_q : '0;
            r_resp     <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            r_last     <= (s_axi.arlen == '0);
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt + LEN_W'(1);
              r_idx  <= rd_idx_c;
              r_data <= rd_ok_c ? ram_q : '0;
              r_resp <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
              r_last <= ((r_cnt + LEN_W'(1)) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = b_valid;
  assign s_axi.bid     = w_id;
  assign s_axi.bresp   = b_resp;
  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = r_valid;
  assign s_axi.rid     = r_id;
  assign s_axi.rdata   = r_data;
  assign s_axi.rresp   = r_resp;
  assign s_axi.rlast   = r_last;
endmodule

// File: tb/tb_s_axi_mem.sv
// Directed self-checking bench for s_axi_mem (64 x 32-bit words at 0x40000000).
module tb_s_axi_mem;
  import s_axi_mem_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  s_axi_mem_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  s_axi_mem #(
    .S_TARGET_SLAVE_BASE_ADDR (64'h4000_0000),
    .S_AXI_ID_WIDTH           (1),
    .S_AXI_ADDR_WIDTH         (32),
    .S_AXI_DATA_WIDTH         (32),
    .MEM_DEPTH                (64)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi        (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rresp_buf [16];
  logic        rlast_buf [16];
  logic        rid_got;
  logic        bid_got;
  logic [1:0]  bresp_got;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed no handshake expected one within bound", tag);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] strb, input int nbeats,
                          input logic id, output logic got_id, output logic [1:0] got_resp);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
    bus.awburst = burst; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout("aw_wait");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      bus.wdata = wbuf[b]; bus.wstrb = strb; bus.wlast = (b == nbeats - 1); bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin @(posedge clk); #1; n++; end
      if (n == 50) timeout("w_wait");
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout("b_wait");
    got_id = bus.bid;
    got_resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic id, input bit toggle, input string tag);
    int n;
    int k;
    int cyc;
    bit stalled;
    logic [31:0] sd;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout({tag, "_ar_wait"});
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check({tag, "_first_rvalid"}, 32'(bus.rvalid), 32'd1);
    k = 0; cyc = 0; stalled = 1'b0; sd = '0;
    while (k <= int'(len) && cyc < 200) begin
      bus.rready = toggle ? cyc[0] : 1'b1;
      if (bus.rvalid) begin
        if (stalled) check({tag, "_stall_hold"}, bus.rdata, sd);
        if (bus.rready) begin
          rbuf[k] = bus.rdata; rresp_buf[k] = bus.rresp; rlast_buf[k] = bus.rlast;
          rid_got = bus.rid; k++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; sd = bus.rdata;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    if (k <= int'(len)) timeout({tag, "_r_beats"});
    check({tag, "_arready_after"}, 32'(bus.arready), 32'd1);
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset values and first cycle after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    areset = 1'b0;
    @(posedge clk); #1;
    check("rel_awready", 32'(bus.awready), 32'd1);
    check("rel_arready", 32'(bus.arready), 32'd1);

    // 16-beat INCR write, then read back with rready toggling
    for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
    wr_burst(BASE, 8'd15, BURST_INCR, 3'd2, 4'hF, 16, 1'b1, bid_got, bresp_got);
    check("w16_bid",   32'(bid_got),   32'd1);
    check("w16_bresp", 32'(bresp_got), 32'(RESP_OKAY));
    rd_burst(BASE, 8'd15, 3'd2, 1'b1, 1'b1, "r16");
    check("r16_rid", 32'(rid_got), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("r16_data", rbuf[i], 32'(i));
      check("r16_last", 32'(rlast_buf[i]), (i == 15) ? 32'd1 : 32'd0);
      check("r16_resp", 32'(rresp_buf[i]), 32'(RESP_OKAY));
    end

    // Partial-strobe write merges with existing word 0x10
    wbuf[0] = 32'h1122_3344;
    wr_burst(BASE + 32'h40, 8'd0, BURST_INCR, 3'd2, 4'hF, 1, 1'b0, bid_got, bresp_got);
    check("full_bresp", 32'(bresp_got), 32'(RESP_OKAY));
    wbuf[0] = 32'hAABB_CCDD;
    wr_burst(BASE + 32'h40, 8'd0, BURST_INCR, 3'd2, 4'b0101, 1, 1'b0, bid_got, bresp_got);
    check("strb_bresp", 32'(bresp_got), 32'(RESP_OKAY));
    check("strb_bid",   32'(bid_got),   32'd0);
    rd_burst(BASE + 32'h40, 8'd0, 3'd2, 1'b0, 1'b0, "strb");
    check("strb_data", rbuf[0], 32'h11BB_33DD);
    check("strb_last", 32'(rlast_buf[0]), 32'd1);

    // 4-beat burst straddling the top of memory
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    wr_burst(BASE + 32'(62 * 4), 8'd3, BURST_INCR, 3'd2, 4'hF, 4, 1'b0, bid_got, bresp_got);
    check("edge_bresp", 32'(bresp_got), 32'(RESP_SLVERR));
    rd_burst(BASE + 32'(62 * 4), 8'd3, 3'd2, 1'b0, 1'b0, "edge");
    check("edge_d0", rbuf[0], 32'hA0);
    check("edge_d1", rbuf[1], 32'hA1);
    check("edge_d2", rbuf[2], 32'h0);
    check("edge_d3", rbuf[3], 32'h0);
    check("edge_r0", 32'(rresp_buf[0]), 32'(RESP_OKAY));
    check("edge_r1", 32'(rresp_buf[1]), 32'(RESP_OKAY));
    check("edge_r2", 32'(rresp_buf[2]), 32'(RESP_SLVERR));
    check("edge_r3", 32'(rresp_buf[3]), 32'(RESP_SLVERR));
    check("edge_last", 32'(rlast_buf[3]), 32'd1);

    // FIXED burst is refused and leaves memory alone
    wbuf[0] = 32'h55;
    wr_burst(BASE + 32'h80, 8'd0, BURST_INCR, 3'd2, 4'hF, 1, 1'b0, bid_got, bresp_got);
    wbuf[0] = 32'h99;
    wr_burst(BASE + 32'h80, 8'd0, 2'b00, 3'd2, 4'hF, 1, 1'b0, bid_got, bresp_got);
    check("fixed_bresp", 32'(bresp_got), 32'(RESP_SLVERR));
    rd_burst(BASE + 32'h80, 8'd0, 3'd2, 1'b0, 1'b0, "fixed");
    check("fixed_keep", rbuf[0], 32'h55);

    // Narrow read size and below-base read both error with zero data
    rd_burst(BASE + 32'h80, 8'd0, 3'd1, 1'b0, 1'b0, "narrow");
    check("narrow_resp", 32'(rresp_buf[0]), 32'(RESP_SLVERR));
    check("narrow_data", rbuf[0], 32'h0);
    rd_burst(BASE - 32'd4, 8'd0, 3'd2, 1'b0, 1'b0, "below");
    check("below_resp", 32'(rresp_buf[0]), 32'(RESP_SLVERR));
    check("below_data", rbuf[0], 32'h0);

    // Beat-count mismatches: early wlast, and an extra beat that is dropped
    wbuf[0] = 32'd1; wbuf[1] = 32'd2;
    wr_burst(BASE + 32'hC0, 8'd1, BURST_INCR, 3'd2, 4'hF, 2, 1'b0, bid_got, bresp_got);
    check("pre_bresp", 32'(bresp_got), 32'(RESP_OKAY));
    wr_burst(BASE + 32'hC0, 8'd1, BURST_INCR, 3'd2, 4'hF, 1, 1'b0, bid_got, bresp_got);
    check("early_bresp", 32'(bresp_got), 32'(RESP_SLVERR));
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
    wr_burst(BASE + 32'hC0, 8'd0, BURST_INCR, 3'd2, 4'hF, 2, 1'b1, bid_got, bresp_got);
    check("extra_bresp", 32'(bresp_got), 32'(RESP_SLVERR));
    check("extra_bid",   32'(bid_got),   32'd1);
    rd_burst(BASE + 32'hC0, 8'd1, 3'd2, 1'b0, 1'b0, "extra");
    check("extra_d0", rbuf[0], 32'hC0);
    check("extra_d1", rbuf[1], 32'd2);

    // Reset during beat 5 of a read aborts it; memory survives
    bus.arid = 1'b0; bus.araddr = BASE; bus.arlen = 8'd15; bus.arsize = 3'd2;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_beat4", bus.rdata, 32'd4);
    areset = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1;
    check("abort_rvalid",  32'(bus.rvalid),  32'd0);
    check("abort_arready", 32'(bus.arready), 32'd0);
    areset = 1'b0;
    @(posedge clk); #1;
    check("abort_rel_arready", 32'(bus.arready), 32'd1);
    rd_burst(BASE, 8'd15, 3'd2, 1'b0, 1'b0, "reread");
    for (int i = 0; i < 16; i++) check("reread_data", rbuf[i], 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
